fetch_queue: RTL
================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, instruction queue entries (power of two, at least 2).
REQ-002 SHALL have parameter RESET_PC, default 30'h0, word address fetched first after reset.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port redirect, input, 1 bit: branch/jump taken; flush and refetch.
REQ-006 SHALL have port redirect_pc, input, [31:2]: new fetch word address.
REQ-007 SHALL have port imem_req, output, 1 bit: instruction memory read request.
REQ-008 SHALL have port imem_addr, output, [31:2]: request word address.
REQ-009 SHALL have port imem_ack, input, 1 bit: request completes in any cycle where imem_req && imem_ack.
REQ-010 SHALL have port imem_rdata, input, 32 bits: instruction, valid when imem_ack is high.
REQ-011 SHALL have port out_valid, output, 1 bit: queue head valid toward IF/ID.
REQ-012 SHALL have port out_ready, input, 1 bit: IF/ID write enable; pop when out_valid && out_ready.
REQ-013 SHALL have port out_instr, output, 32 bits: head instruction.
REQ-014 SHALL have port out_fourpc, output, [31:2]: head fetch address + 1 (word PC+4).
REQ-015 SHALL have port count, output, $clog2(DEPTH)+1 bits: current occupancy.

Function
REQ-016 SHALL hold fetch pointer fpc[31:2] and FSM states FETCH and DROP.
REQ-017 In FETCH, SHALL set imem_req = (count < DEPTH) and imem_addr = fpc.
REQ-018 Once imem_req is high without ack, SHALL keep imem_req and imem_addr stable until ack, including across redirect.
REQ-019 In FETCH, on req && ack with no redirect, SHALL push {imem_rdata, fpc+1} and set fpc <= fpc+1 (30-bit wrap).
REQ-020 SHALL sustain one instruction per cycle when ack is returned in the request cycle and the queue is not full.
REQ-021 On redirect in FETCH with req && !ack, SHALL latch the pending address into drop_addr, set fpc <= redirect_pc, and enter DROP.
REQ-022 On redirect in FETCH with no request outstanding, or with req && ack, SHALL discard any response, set fpc <= redirect_pc, and remain in FETCH.
REQ-023 In DROP, SHALL drive imem_req = 1 and imem_addr = drop_addr, discard data on ack, then return to FETCH.
REQ-024 On redirect in DROP, SHALL update fpc <= redirect_pc and remain in DROP.
REQ-025 On any redirect, SHALL reset count and both pointers to 0 the next cycle and force out_valid = 0 in the redirect cycle.
REQ-026 SHALL set out_valid = (count != 0) && !redirect; out_instr and out_fourpc SHALL come from the head entry.
REQ-027 On simultaneous push and pop, SHALL leave count unchanged and advance both pointers; pointers SHALL wrap modulo DEPTH.
REQ-028 When full, SHALL keep imem_req low; SHALL never exceed DEPTH entries or hold more than one outstanding request.
REQ-029 On pop with out_ready while empty, SHALL make no state change.

Reset
REQ-030 On rst low, SHALL immediately and asynchronously set: state FETCH, fpc RESET_PC, count 0, pointers 0, out_valid 0, imem_req 0.
REQ-031 After reset release, SHALL fetch RESET_PC first.
REQ-032 Reset mid-transaction SHALL abandon the request without a DROP; memory SHALL treat dropped req as cancelled.

Structure
REQ-033 SHALL take DEPTH, RESET_PC and the FSM state encodings from the shared pipeline package.
REQ-034 SHALL place queue storage and pointers in one sub-module, fq_fifo (push/pop/flush, data width 62 bits).

Verification
REQ-035 Reset, ack always high: addresses 0,1,2,3 issued on consecutive cycles; out_fourpc 1,2,3,4 with matching instructions.
REQ-036 out_ready low, ack high: count reaches 4, imem_req drops; one pop -> imem_req high again next cycle.
REQ-037 Ack delayed 3 cycles, redirect to 30'h40 in the second wait cycle: imem_req and addr held; response discarded; next request at 30'h40.
REQ-038 Full queue, redirect to 30'h100: out_valid 0 that cycle; count 0 next; first output fourpc 30'h101.
REQ-039 Push and pop in the same cycle at count 2: count stays 2; order preserved across pointer wrap.
REQ-040 rst asserted with a request outstanding: imem_req and out_valid go low without a clock edge; restart at RESET_PC.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// Shared pipeline package for the fetch stage: queue sizing, reset PC,
// fetch FSM state encoding and the queue entry layout.
package fetch_queue_pkg;

  localparam int unsigned FQ_DEPTH    = 4;
  localparam logic [29:0] FQ_RESET_PC = 30'h0;
  localparam int unsigned FQ_ENTRY_W  = 62;

  typedef enum logic {
    FETCH = 1'b0,
    DROP  = 1'b1
  } fqState_e;

  // One queued instruction together with its word PC+4.
  typedef struct packed {
    logic [31:0] instr;
    logic [29:0] fourPc;
  } fqEntry_t;

  // Next sequential word address, wrapping at 30 bits.
  function automatic logic [29:0] nextWord(input logic [29:0] pc);
    return pc + 30'd1;
  endfunction

endpackage

// File: rtl/fetch_queue_fifo.sv
// Circular instruction queue with push, pop and synchronous flush.
// DEPTH must be a power of two so the pointers wrap naturally.
module fq_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 62
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           wrData,
  output logic [WIDTH-1:0]           rdData,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr;
  logic [AW-1:0]    rdPtr;
  logic [CW-1:0]    cnt;
  logic             doPush;
  logic             doPop;

  assign full   = (cnt == CW'(DEPTH));
  assign empty  = (cnt == '0);
  assign doPush = push && !full && !flush;
  assign doPop  = pop && !empty && !flush;
  assign rdData = mem[rdPtr];
  assign count  = cnt;

  // Storage write; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (doPush) begin
      mem[wrPtr] <= wrData;
    end
  end

  // Pointer and occupancy update; flush empties the queue in one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      cnt   <= '0;
    end else if (flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      cnt   <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      case ({doPush, doPop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch unit: issues sequential word fetches into a small
// queue feeding IF/ID, and handles redirects including a request that is
// still waiting for its acknowledge (DROP state swallows that response).
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH    = FQ_DEPTH,
  parameter logic [29:0] RESET_PC = FQ_RESET_PC
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   redirect,
  input  logic [31:2]            redirect_pc,
  output logic                   imem_req,
  output logic [31:2]            imem_addr,
  input  logic                   imem_ack,
  input  logic [31:0]            imem_rdata,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_instr,
  output logic [31:2]            out_fourpc,
  output logic [$clog2(DEPTH):0] count
);

  fqState_e    state;
  fqState_e    stateNext;
  logic [31:2] fpc;
  logic [31:2] fpcNext;
  logic [31:2] dropAddr;
  logic [31:2] dropAddrNext;
  logic        reqRaw;
  logic [31:2] addrRaw;
  logic        pushEn;
  logic        popEn;
  logic        fifoFull;
  logic        fifoEmpty;
  fqEntry_t    pushEntry;
  fqEntry_t    headEntry;

  // Request is gated by the reset input so it drops with no clock edge.
  assign imem_req   = rst && reqRaw;
  assign imem_addr  = addrRaw;
  assign out_valid  = !fifoEmpty && !redirect;
  assign popEn      = out_valid && out_ready;
  assign pushEntry  = {imem_rdata, nextWord(fpc)};
  assign out_instr  = headEntry.instr;
  assign out_fourpc = headEntry.fourPc;

  // FSM state, fetch pointer and pending-drop address registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= FETCH;
      fpc      <= RESET_PC;
      dropAddr <= '0;
    end else begin
      state    <= stateNext;
      fpc      <= fpcNext;
      dropAddr <= dropAddrNext;
    end
  end

  // Next-state, request generation and push decision.
  always_comb begin
    stateNext    = state;
    fpcNext      = fpc;
    dropAddrNext = dropAddr;
    reqRaw       = 1'b0;
    addrRaw      = fpc;
    pushEn       = 1'b0;
    unique case (state)
      FETCH: begin
        reqRaw  = !fifoFull;
        addrRaw = fpc;
        if (redirect) begin
          fpcNext = redirect_pc;
          if (reqRaw && !imem_ack) begin
            dropAddrNext = fpc;
            stateNext    = DROP;
          end
        end else if (reqRaw && imem_ack) begin
          pushEn  = 1'b1;
          fpcNext = nextWord(fpc);
        end
      end
      DROP: begin
        reqRaw  = 1'b1;
        addrRaw = dropAddr;
        if (redirect) begin
          fpcNext = redirect_pc;
        end
        // An ack completes the abandoned request even if a fresh redirect
        // arrives alongside it; re-issuing dropAddr would only waste a slot.
        if (imem_ack) begin
          stateNext = FETCH;
        end
      end
      default: begin
        stateNext = FETCH;
      end
    endcase
  end

  fq_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (FQ_ENTRY_W)
  ) uFifo (
    .clk    (clk),
    .rst    (rst),
    .push   (pushEn),
    .pop    (popEn),
    .flush  (redirect),
    .wrData (pushEntry),
    .rdData (headEntry),
    .count  (count),
    .full   (fifoFull),
    .empty  (fifoEmpty)
  );

endmodule
